// File: rtl/sc_hex_out_port.sv
// sc_hex_out_port: binary-to-BCD (double-dabble) converter driving six active-low 7-segment displays.
// Latency: write to done/hex update is 22 cycles for values <= 999999 and 2 cycles for overflow values.
// Backpressure: none. A write while busy lands in a one-deep pending slot (last write wins), consumed on COMMIT exit.
//
// Ports:
//   clock            system clock, all state on the rising edge
//   resetn           asynchronous active-low reset
//   wr_en, wr_data   one-cycle write strobe and 32-bit unsigned value to display
//   busy             high while a conversion is in CHECK/SHIFT/COMMIT
//   done             one-cycle pulse when new digits reach hex5..hex0
//   ovf              last committed value was >= 1000000
//   hex5..hex0       active-low segments {g,f,e,d,c,b,a}; hex5 is the most significant digit
//
// Build option: define HEX_LEADING_ZERO_BLANK_EN to blank leading zero digits (hex0 always shown).

module sc_hex_out_port #(
   parameter logic [6:0] SEG_BLANK = 7'h7F,
   parameter logic [6:0] SEG_DASH  = 7'h3F,
   parameter int         CONV_BITS = 20
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [6:0]  hex5,
   output logic [6:0]  hex4,
   output logic [6:0]  hex3,
   output logic [6:0]  hex2,
   output logic [6:0]  hex1,
   output logic [6:0]  hex0
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_SHIFT  = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   localparam logic [31:0] MAX_VAL  = 32'd999999;
   localparam logic [4:0]  LAST_CNT = 5'(CONV_BITS - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [31:0]      r_src;        // value under conversion
   logic             r_ovf_case;   // src exceeded 999999, latched in CHECK
   logic [23:0]      r_bcd;        // six BCD nibbles, nibble 0 = units
   logic [19:0]      r_bin;        // binary bits still to be shifted in
   logic [4:0]       r_cnt;        // shift cycles completed

   logic             r_pend_vld;
   logic [31:0]      r_pend_dat;

   logic [5:0][6:0]  r_hex;        // index 0 = hex0
   logic             r_done;
   logic             r_ovf;

   logic             w_src_big;
   logic             w_restart;
   logic [23:0]      w_bcd_adj;
   logic [5:0][6:0]  w_hex_new;

   // Active-low segment pattern for one BCD digit. Nibbles above 9 are
   // unreachable from the converter but blank cleanly if ever seen.
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   assign w_src_big = (r_src > MAX_VAL);

   // A write in the COMMIT cycle itself counts as pending and is newer than
   // anything already held, so it takes priority on restart.
   assign w_restart = r_pend_vld | wr_en;

   //---------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------
   // FSM next-state
   //---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (wr_en) begin
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            w_state_nxt = w_src_big ? S_COMMIT : S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == LAST_CNT) begin
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_state_nxt = w_restart ? S_CHECK : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------
   // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
   // that it carries correctly into the next decimal digit.
   //---------------------------------------------------------------------
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 6; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   //---------------------------------------------------------------------
   // Segment patterns presented at COMMIT
   //---------------------------------------------------------------------
`ifdef HEX_LEADING_ZERO_BLANK_EN
   logic w_lead;
`endif

   always_comb begin
      w_hex_new = '0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
      w_lead    = 1'b1;
`endif
      if (r_ovf_case) begin
         for (int i = 0; i < 6; i++) begin
            w_hex_new[i] = SEG_DASH;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            w_hex_new[i] = f_seg(r_bcd[4*i +: 4]);
         end
`ifdef HEX_LEADING_ZERO_BLANK_EN
         // Walk down from the top digit, blanking zeros until the first
         // non-zero digit. hex0 is excluded so a value of 0 still shows "0".
         for (int i = 5; i >= 1; i--) begin
            if (w_lead && (r_bcd[4*i +: 4] == 4'd0)) begin
               w_hex_new[i] = SEG_BLANK;
            end else begin
               w_lead = 1'b0;
            end
         end
`endif
      end
   end

   //---------------------------------------------------------------------
   // Datapath, pending slot and registered outputs
   //---------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_src      <= '0;
         r_ovf_case <= 1'b0;
         r_bcd      <= '0;
         r_bin      <= '0;
         r_cnt      <= '0;
         r_pend_vld <= 1'b0;
         r_pend_dat <= '0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_hex[i] <= SEG_BLANK;
         end
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (wr_en) begin
                  r_src <= wr_data;
               end
            end
            S_CHECK: begin
               r_ovf_case <= w_src_big;
               r_bcd      <= '0;
               r_bin      <= r_src[19:0];
               r_cnt      <= '0;
               if (wr_en) begin
                  r_pend_vld <= 1'b1;
                  r_pend_dat <= wr_data;
               end
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
               r_cnt          <= r_cnt + 5'd1;
               if (wr_en) begin
                  r_pend_vld <= 1'b1;
                  r_pend_dat <= wr_data;
               end
            end
            S_COMMIT: begin
               r_done <= 1'b1;
               r_ovf  <= r_ovf_case;
               r_hex  <= w_hex_new;
               if (wr_en) begin
                  r_src      <= wr_data;
                  r_pend_vld <= 1'b0;
               end else if (r_pend_vld) begin
                  r_src      <= r_pend_dat;
                  r_pend_vld <= 1'b0;
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign ovf  = r_ovf;
   assign hex0 = r_hex[0];
   assign hex1 = r_hex[1];
   assign hex2 = r_hex[2];
   assign hex3 = r_hex[3];
   assign hex4 = r_hex[4];
   assign hex5 = r_hex[5];

endmodule

// File: tb/tb_sc_hex_out_port.sv
// Testbench for sc_hex_out_port: directed scenarios plus randomized writes,
// checked every cycle against a transaction-level model of the display port.
module tb_sc_hex_out_port;

   logic        clock   = 1'b0;
   logic        resetn  = 1'b1;
   logic        wr_en   = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy, done, ovf;
   logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_on = 1'b0;

   always #5 clock = ~clock;

   sc_hex_out_port dut (
      .clock   (clock),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .hex5    (hex5),
      .hex4    (hex4),
      .hex3    (hex3),
      .hex2    (hex2),
      .hex1    (hex1),
      .hex0    (hex0)
   );

   logic [6:0] d_hex [6];
   assign d_hex[0] = hex0;
   assign d_hex[1] = hex1;
   assign d_hex[2] = hex2;
   assign d_hex[3] = hex3;
   assign d_hex[4] = hex4;
   assign d_hex[5] = hex5;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   // A conversion is a countdown of edges until its commit: 22 for
   // displayable values, 2 for overflow values.
   logic        m_busy     = 1'b0;
   int          m_rem      = 0;
   logic [31:0] m_val      = '0;
   logic [31:0] m_pend     = '0;
   logic        m_pend_vld = 1'b0;
   logic [6:0]  m_hex [6]  = '{default: 7'h7F};
   logic        m_ovf      = 1'b0;
   logic        m_done     = 1'b0;

   task automatic m_start(input logic [31:0] v);
      m_busy = 1'b1;
      m_val  = v;
      m_rem  = (v > 32'd999999) ? 2 : 22;
   endtask

   task automatic m_commit(input logic [31:0] v);
      int dig [6];
      int top;
      m_done = 1'b1;
      if (v > 32'd999999) begin
         m_ovf = 1'b1;
         for (int i = 0; i < 6; i++) m_hex[i] = 7'h3F;
      end else begin
         m_ovf = 1'b0;
         top = 0;
         for (int i = 0; i < 6; i++) begin
            dig[i] = (int'(v) / (10 ** i)) % 10;
            if (dig[i] != 0) top = i;
         end
         for (int i = 0; i < 6; i++) begin
`ifdef HEX_LEADING_ZERO_BLANK_EN
            m_hex[i] = (i > top) ? 7'h7F : seg_of(dig[i]);
`else
            m_hex[i] = seg_of(dig[i]);
`endif
         end
      end
   endtask

   initial forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
         m_busy     = 1'b0;
         m_rem      = 0;
         m_pend_vld = 1'b0;
         m_ovf      = 1'b0;
         m_done     = 1'b0;
         for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (wr_en) m_start(wr_data);
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_commit(m_val);
               if (wr_en) begin
                  m_start(wr_data);
                  m_pend_vld = 1'b0;
               end else if (m_pend_vld) begin
                  m_start(m_pend);
                  m_pend_vld = 1'b0;
               end else begin
                  m_busy = 1'b0;
               end
            end else if (wr_en) begin
               m_pend     = wr_data;
               m_pend_vld = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clock);
      if (chk_on) begin
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_done));
         chk("ovf",  64'(ovf),  64'(m_ovf));
         for (int i = 0; i < 6; i++)
            chk($sformatf("hex%0d", i), 64'(d_hex[i]), 64'(m_hex[i]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse(input logic [31:0] v);
      @(negedge clock);
      wr_en   = 1'b1;
      wr_data = v;
      @(negedge clock);
      wr_en   = 1'b0;
   endtask

   task automatic wait_done(input string nm, output int cyc);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (done !== 1'b1 && cyc < 100);
      if (done !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no done within %0d cycles", nm, cyc);
      end
   endtask

   function automatic logic [63:0] hexv();
      return 64'({hex5, hex4, hex3, hex2, hex1, hex0});
   endfunction

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int cyc;
      logic [31:0] v;

      #1 resetn = 1'b0;
      #1 chk_on = 1'b1;
      repeat (5) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("rst_hex",  hexv(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovf",  64'(ovf),  64'd0);
      repeat (5) @(negedge clock);
      chk("idle_hex", hexv(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));

      // 123456
      pulse(32'd123456);
      wait_done("lat_123456", cyc);
      chk("lat_123456", 64'(cyc), 64'd22);
      chk("hex_123456", hexv(), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
      chk("ovf_123456", 64'(ovf), 64'd0);
      @(negedge clock);
      chk("busy_after_done", 64'(busy), 64'd0);

      // 0 and 999999
      pulse(32'd0);
      wait_done("lat_0", cyc);
`ifdef HEX_LEADING_ZERO_BLANK_EN
      chk("hex_0", hexv(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
      chk("hex_0", hexv(), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}));
`endif
      pulse(32'd999999);
      wait_done("lat_999999", cyc);
      chk("hex_999999", hexv(), 64'({7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}));
      chk("ovf_999999", 64'(ovf), 64'd0);

      // overflow, then recovery
      pulse(32'd1000000);
      wait_done("lat_ovf", cyc);
      chk("lat_ovf", 64'(cyc), 64'd2);
      chk("hex_ovf", hexv(), 64'({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}));
      chk("ovf_set", 64'(ovf), 64'd1);
      @(negedge clock);
      pulse(32'd7);
      wait_done("lat_7", cyc);
      chk("lat_7", 64'(cyc), 64'd22);
      chk("hex0_7", 64'(hex0), 64'h78);
      chk("ovf_clr", 64'(ovf), 64'd0);
`ifdef HEX_LEADING_ZERO_BLANK_EN
      chk("hex5_7", 64'(hex5), 64'h7F);
`else
      chk("hex5_7", 64'(hex5), 64'h40);
`endif

      // writes while busy: last pending wins
      pulse(32'd111111);
      repeat (3) @(negedge clock);
      pulse(32'd222222);
      repeat (3) @(negedge clock);
      pulse(32'd333333);
      wait_done("pend_first", cyc);
      chk("pend_first", hexv(), 64'({7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79}));
      wait_done("pend_second", cyc);
      chk("pend_second_lat", 64'(cyc), 64'd22);
      chk("pend_second", hexv(), 64'({7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30}));
      @(negedge clock);
      chk("pend_drained", 64'(busy), 64'd0);

      // reset mid-conversion
      pulse(32'd654321);
      repeat (10) @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      chk("abort_hex",  hexv(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (30) @(negedge clock);
      chk("abort_nodisp", hexv(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
      pulse(32'd42);
      wait_done("lat_42", cyc);
      chk("lat_42", 64'(cyc), 64'd22);
      chk("hex10_42", 64'({hex1, hex0}), 64'({7'h19, 7'h24}));
`ifdef HEX_LEADING_ZERO_BLANK_EN
      chk("hex2_42", 64'(hex2), 64'h7F);
`else
      chk("hex2_42", 64'(hex2), 64'h40);
`endif

      // randomized writes at random spacing, checked by the model each cycle
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 9))
            0:       v = $urandom;
            1:       v = 32'd999999 + 32'($urandom_range(0, 1));
            default: v = 32'($urandom_range(0, 999999));
         endcase
         pulse(v);
         repeat ($urandom_range(0, 30)) @(negedge clock);
      end
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
      chk("drain_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
